cp_wb_arbiter: RTL and testbench

CP writeback arbiter. It produces the single RF write port (address, data, enable) consumed by the CP register file. It merges fixed-latency ALU results with variable-latency load responses from data memory. Load responses are buffered in a small queue. A per-register pending scoreboard is exported to ID for load-use and WAW hazard stalls.

---
 rtl/cp_wb_pkg.sv | 27 ++
 rtl/cp_wb_lq.sv | 65 ++++++
 rtl/cp_wb_arbiter.sv | 116 +++++++++++
 tb/tb_cp_wb_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_wb_pkg.sv
// Shared CP writeback definitions: datapath widths, RF write-port record and
// arbitration source encoding, common to the writeback arbiter and CP register file.
package cp_wb_pkg;

   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned RF_INDEX_WIDTH = 5;
   localparam int unsigned RF_NUM_REGS    = 28;

   typedef struct packed {
      logic [RF_INDEX_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]     data;
      logic                      en;
   } wb_port_t;

   typedef enum logic [1:0] {
      SrcNone,
      SrcAlu,
      SrcLq,
      SrcMem
   } wb_src_e;

   // r0 is hardwired to zero and indices past the last architected register do not exist.
   function automatic logic rf_addr_writable(input logic [RF_INDEX_WIDTH-1:0] addr);
      return (addr != '0) && ({1'b0, addr} < (RF_INDEX_WIDTH + 1)'(RF_NUM_REGS));
   endfunction

endpackage

// File: rtl/cp_wb_lq.sv
// Load-response queue: synchronous circular FIFO with occupancy counter.
// Push is ignored when full; pop is ignored when empty.
module cp_wb_lq #(
   parameter  int unsigned Width = 37,
   parameter  int unsigned Depth = 4,
   localparam int unsigned PtrW  = $clog2(Depth),
   localparam int unsigned CntW  = $clog2(Depth) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) count_d = count_q + CntW'(1);
      if (do_pop && !do_push) count_d = count_q - CntW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      count_q <= CntW'(Depth));
   a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
      pop_i |-> !empty_o);

endmodule

// File: rtl/cp_wb_arbiter.sv
// CP writeback arbiter: merges ALU results and buffered load responses onto the single
// RF write port, and tracks outstanding loads per register for ID hazard stalls.
module cp_wb_arbiter
   import cp_wb_pkg::*;
#(
   parameter  int unsigned LQ_DEPTH = 4,
   localparam int unsigned CntW     = $clog2(LQ_DEPTH) + 1
) (
   input  logic                      iClk,
   input  logic                      iReset,
   input  logic                      iEX_WB_Valid,
   input  logic [RF_INDEX_WIDTH-1:0] iEX_WB_Addr,
   input  logic [DATA_WIDTH-1:0]     iEX_WB_Data,
   input  logic                      iID_WB_Load_Issue,
   input  logic [RF_INDEX_WIDTH-1:0] iID_WB_Load_Addr,
   input  logic                      iMEM_WB_Valid,
   input  logic [RF_INDEX_WIDTH-1:0] iMEM_WB_Addr,
   input  logic [DATA_WIDTH-1:0]     iMEM_WB_Data,
   output logic                      oWB_MEM_Ready,
   output logic [RF_NUM_REGS-1:0]    oWB_ID_Pending,
   output logic [RF_INDEX_WIDTH-1:0] oWB_RF_Write_Addr,
   output logic [DATA_WIDTH-1:0]     oWB_RF_Write_Data,
   output logic                      oWB_RF_Write_Enable,
   output logic [CntW-1:0]           oWB_LQ_Count
);

   localparam int unsigned EntryW = RF_INDEX_WIDTH + DATA_WIDTH;

   wb_src_e                   sel_src;
   logic [RF_INDEX_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0]     sel_data;
   logic                      mem_accept;
   logic                      lq_push, lq_pop, lq_full, lq_empty;
   logic [EntryW-1:0]         lq_head;
   logic                      load_sel;
   wb_port_t                  wb_q, wb_d;
   logic [RF_NUM_REGS-1:0]    pending_q, pending_d;

   // Ready depends only on the occupancy register, never on this cycle's pop.
   assign oWB_MEM_Ready = !lq_full;
   assign mem_accept    = iMEM_WB_Valid && !lq_full;

   always_comb begin
      sel_src  = SrcNone;
      sel_addr = '0;
      sel_data = '0;
      if (iEX_WB_Valid) begin
         sel_src  = SrcAlu;
         sel_addr = iEX_WB_Addr;
         sel_data = iEX_WB_Data;
      end else if (!lq_empty) begin
         sel_src              = SrcLq;
         {sel_addr, sel_data} = lq_head;
      end else if (mem_accept) begin
         sel_src  = SrcMem;
         sel_addr = iMEM_WB_Addr;
         sel_data = iMEM_WB_Data;
      end
   end

   assign lq_pop   = (sel_src == SrcLq);
   assign lq_push  = mem_accept && (sel_src != SrcMem);
   assign load_sel = (sel_src == SrcLq) || (sel_src == SrcMem);

   cp_wb_lq #(
      .Width (EntryW),
      .Depth (LQ_DEPTH)
   ) u_lq (
      .clk_i   (iClk),
      .rst_i   (iReset),
      .push_i  (lq_push),
      .wdata_i ({iMEM_WB_Addr, iMEM_WB_Data}),
      .pop_i   (lq_pop),
      .rdata_o (lq_head),
      .full_o  (lq_full),
      .empty_o (lq_empty),
      .count_o (oWB_LQ_Count)
   );

   // Dropped writes (r0 / nonexistent register) leave address and data untouched.
   always_comb begin
      wb_d    = wb_q;
      wb_d.en = 1'b0;
      if ((sel_src != SrcNone) && rf_addr_writable(sel_addr)) begin
         wb_d.en   = 1'b1;
         wb_d.addr = sel_addr;
         wb_d.data = sel_data;
      end
   end

   // Clear on load selection first so a same-cycle issue to that register wins.
   always_comb begin
      pending_d = pending_q;
      for (int i = 1; i < RF_NUM_REGS; i++) begin
         if (load_sel && (sel_addr == RF_INDEX_WIDTH'(i))) pending_d[i] = 1'b0;
         if (iID_WB_Load_Issue && (iID_WB_Load_Addr == RF_INDEX_WIDTH'(i))) pending_d[i] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         wb_q      <= '0;
         pending_q <= '0;
      end else begin
         wb_q      <= wb_d;
         pending_q <= pending_d;
      end
   end

   assign oWB_RF_Write_Addr   = wb_q.addr;
   assign oWB_RF_Write_Data   = wb_q.data;
   assign oWB_RF_Write_Enable = wb_q.en;
   assign oWB_ID_Pending      = pending_q;

endmodule

// File: tb/tb_cp_wb_arbiter.sv
// Bench for cp_wb_arbiter: queue-level reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_cp_wb_arbiter;

   localparam int unsigned LQD = 4;

   logic        iClk = 1'b0;
   logic        iReset = 1'b0;
   logic        iEX_WB_Valid = 1'b0;
   logic [4:0]  iEX_WB_Addr = '0;
   logic [31:0] iEX_WB_Data = '0;
   logic        iID_WB_Load_Issue = 1'b0;
   logic [4:0]  iID_WB_Load_Addr = '0;
   logic        iMEM_WB_Valid = 1'b0;
   logic [4:0]  iMEM_WB_Addr = '0;
   logic [31:0] iMEM_WB_Data = '0;
   logic        oWB_MEM_Ready;
   logic [27:0] oWB_ID_Pending;
   logic [4:0]  oWB_RF_Write_Addr;
   logic [31:0] oWB_RF_Write_Data;
   logic        oWB_RF_Write_Enable;
   logic [2:0]  oWB_LQ_Count;

   cp_wb_arbiter #(
      .LQ_DEPTH (LQD)
   ) dut (
      .iClk                (iClk),
      .iReset              (iReset),
      .iEX_WB_Valid        (iEX_WB_Valid),
      .iEX_WB_Addr         (iEX_WB_Addr),
      .iEX_WB_Data         (iEX_WB_Data),
      .iID_WB_Load_Issue   (iID_WB_Load_Issue),
      .iID_WB_Load_Addr    (iID_WB_Load_Addr),
      .iMEM_WB_Valid       (iMEM_WB_Valid),
      .iMEM_WB_Addr        (iMEM_WB_Addr),
      .iMEM_WB_Data        (iMEM_WB_Data),
      .oWB_MEM_Ready       (oWB_MEM_Ready),
      .oWB_ID_Pending      (oWB_ID_Pending),
      .oWB_RF_Write_Addr   (oWB_RF_Write_Addr),
      .oWB_RF_Write_Data   (oWB_RF_Write_Data),
      .oWB_RF_Write_Enable (oWB_RF_Write_Enable),
      .oWB_LQ_Count        (oWB_LQ_Count)
   );

   always #5 iClk = ~iClk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: a list of waiting responses, a pending bit per register and the
   // last RF write; stepped on every rising edge from the inputs seen there.
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        m_q[$];
   logic [27:0] m_pend = '0;
   logic        m_en   = 1'b0;
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;
   bit          m_live = 1'b0;

   task automatic model_step();
      bit          acc, sel, ld_sel;
      logic [4:0]  sa;
      logic [31:0] sd;
      ent_t        e;
      if (iReset) begin
         m_q.delete();
         m_pend = '0;
         m_en   = 1'b0;
         m_addr = '0;
         m_data = '0;
         m_live = 1'b1;
         return;
      end
      acc    = iMEM_WB_Valid && (m_q.size() < LQD);
      sel    = 1'b0;
      ld_sel = 1'b0;
      sa     = '0;
      sd     = '0;
      if (iEX_WB_Valid) begin
         sel = 1'b1;
         sa  = iEX_WB_Addr;
         sd  = iEX_WB_Data;
      end else if (m_q.size() > 0) begin
         e      = m_q.pop_front();
         sel    = 1'b1;
         ld_sel = 1'b1;
         sa     = e.a;
         sd     = e.d;
      end else if (acc) begin
         sel    = 1'b1;
         ld_sel = 1'b1;
         sa     = iMEM_WB_Addr;
         sd     = iMEM_WB_Data;
         acc    = 1'b0;
      end
      if (acc) m_q.push_back('{iMEM_WB_Addr, iMEM_WB_Data});
      if (ld_sel && sa < 28) m_pend[sa] = 1'b0;
      if (iID_WB_Load_Issue && iID_WB_Load_Addr != 0 && iID_WB_Load_Addr < 28)
         m_pend[iID_WB_Load_Addr] = 1'b1;
      m_en = sel && (sa != 0) && (sa < 28);
      if (m_en) begin
         m_addr = sa;
         m_data = sd;
      end
   endtask

   initial begin
      forever begin
         @(posedge iClk);
         model_step();
         @(negedge iClk);
         if (m_live) begin
            check("model wr_en",   64'(oWB_RF_Write_Enable), 64'(m_en));
            check("model wr_addr", 64'(oWB_RF_Write_Addr),   64'(m_addr));
            check("model wr_data", 64'(oWB_RF_Write_Data),   64'(m_data));
            check("model pending", 64'(oWB_ID_Pending),      64'(m_pend));
            check("model count",   64'(oWB_LQ_Count),        64'(m_q.size()));
            check("model ready",   64'(oWB_MEM_Ready),       64'(m_q.size() < LQD));
         end
      end
   end

   task automatic idle();
      iEX_WB_Valid      = 1'b0;
      iID_WB_Load_Issue = 1'b0;
      iMEM_WB_Valid     = 1'b0;
   endtask

   task automatic alu(input logic [4:0] a, input logic [31:0] d);
      iEX_WB_Valid = 1'b1;
      iEX_WB_Addr  = a;
      iEX_WB_Data  = d;
   endtask

   task automatic ld(input logic [4:0] a);
      iID_WB_Load_Issue = 1'b1;
      iID_WB_Load_Addr  = a;
   endtask

   task automatic rsp(input logic [4:0] a, input logic [31:0] d);
      iMEM_WB_Valid = 1'b1;
      iMEM_WB_Addr  = a;
      iMEM_WB_Data  = d;
   endtask

   task automatic cyc();
      @(negedge iClk);
   endtask

   int         j, n;
   bit         acc;
   logic [4:0] drain_addr[8];
   logic [31:0] drain_data[8];

   initial begin
      // Reset held two cycles with every input active.
      iReset = 1'b1;
      alu(5'd3, 32'h1);
      ld(5'd4);
      rsp(5'd6, 32'h2);
      for (int k = 0; k < 2; k++) begin
         cyc();
         check("reset wr_en",   64'(oWB_RF_Write_Enable), 64'd0);
         check("reset pending", 64'(oWB_ID_Pending),      64'd0);
         check("reset count",   64'(oWB_LQ_Count),        64'd0);
         check("reset ready",   64'(oWB_MEM_Ready),       64'd1);
      end
      iReset = 1'b0;
      idle();
      cyc();
      check("post-reset wr_en", 64'(oWB_RF_Write_Enable), 64'd0);
      check("post-reset ready", 64'(oWB_MEM_Ready),       64'd1);

      // Fall-through of a response into an empty queue.
      ld(5'd5);
      cyc();
      check("ft pending5 set", 64'(oWB_ID_Pending[5]), 64'd1);
      idle();
      cyc();
      rsp(5'd5, 32'hDEADBEEF);
      cyc();
      check("ft wr_en",       64'(oWB_RF_Write_Enable), 64'd1);
      check("ft wr_addr",     64'(oWB_RF_Write_Addr),   64'd5);
      check("ft wr_data",     64'(oWB_RF_Write_Data),   64'hDEADBEEF);
      check("ft pending5 clr", 64'(oWB_ID_Pending[5]),  64'd0);
      check("ft count",       64'(oWB_LQ_Count),        64'd0);
      idle();

      // ALU and response in the same cycle.
      ld(5'd7);
      cyc();
      idle();
      alu(5'd3, 32'h11);
      rsp(5'd7, 32'h22);
      cyc();
      check("conf alu addr", 64'(oWB_RF_Write_Addr), 64'd3);
      check("conf alu data", 64'(oWB_RF_Write_Data), 64'h11);
      check("conf count 1",  64'(oWB_LQ_Count),      64'd1);
      idle();
      cyc();
      check("conf ld en",    64'(oWB_RF_Write_Enable), 64'd1);
      check("conf ld addr",  64'(oWB_RF_Write_Addr),   64'd7);
      check("conf ld data",  64'(oWB_RF_Write_Data),   64'h22);
      check("conf count 0",  64'(oWB_LQ_Count),        64'd0);

      // Fill the queue behind a busy ALU, then drain.
      for (int r = 10; r < 15; r++) begin
         idle();
         ld(5'(r));
         cyc();
      end
      idle();
      j = 0;
      for (int k = 0; k < 6; k++) begin
         alu(5'(20 + k), 32'h100 + 32'(k));
         if (j < 5) rsp(5'(10 + j), 32'hA0 + 32'(j));
         else iMEM_WB_Valid = 1'b0;
         acc = iMEM_WB_Valid && oWB_MEM_Ready;
         cyc();
         if (acc) j++;
         if (k == 3) begin
            check("full count", 64'(oWB_LQ_Count),  64'd4);
            check("full ready", 64'(oWB_MEM_Ready), 64'd0);
         end
      end
      check("full accepted", 64'(j), 64'd4);
      iEX_WB_Valid = 1'b0;
      n = 0;
      for (int c = 0; c < 10; c++) begin
         if (j < 5) rsp(5'(10 + j), 32'hA0 + 32'(j));
         else iMEM_WB_Valid = 1'b0;
         acc = iMEM_WB_Valid && oWB_MEM_Ready;
         cyc();
         if (acc) j++;
         if (oWB_RF_Write_Enable) begin
            if (n < 8) begin
               drain_addr[n] = oWB_RF_Write_Addr;
               drain_data[n] = oWB_RF_Write_Data;
            end
            n++;
         end
      end
      check("drain writes", 64'(n), 64'd5);
      for (int i = 0; i < 5; i++) begin
         check("drain addr", 64'(drain_addr[i]), 64'(10 + i));
         check("drain data", 64'(drain_data[i]), 64'(32'hA0 + 32'(i)));
      end
      idle();

      // Writes to r0 and to a nonexistent register are dropped.
      alu(5'd0, 32'h55);
      cyc();
      check("r0 wr_en",      64'(oWB_RF_Write_Enable), 64'd0);
      check("r0 addr hold",  64'(oWB_RF_Write_Addr),   64'd14);
      idle();
      rsp(5'd30, 32'h66);
      cyc();
      check("r30 wr_en",     64'(oWB_RF_Write_Enable), 64'd0);
      check("r30 data hold", 64'(oWB_RF_Write_Data),   64'hA4);
      idle();

      // New load to a register in the same cycle its response is selected.
      ld(5'd9);
      cyc();
      idle();
      cyc();
      rsp(5'd9, 32'h99);
      ld(5'd9);
      cyc();
      check("same-cyc wr_addr",  64'(oWB_RF_Write_Addr), 64'd9);
      check("same-cyc pending9", 64'(oWB_ID_Pending[9]), 64'd1);
      idle();
      rsp(5'd9, 32'h9A);
      cyc();
      check("second rsp pending9", 64'(oWB_ID_Pending[9]), 64'd0);
      check("second rsp data",     64'(oWB_RF_Write_Data), 64'h9A);
      idle();

      // Reset in the middle of traffic flushes queue and scoreboard.
      ld(5'd15);
      cyc();
      idle();
      for (int k = 0; k < 2; k++) begin
         alu(5'(21 + k), 32'(k + 1));
         rsp(5'(16 + k), 32'hF0 + 32'(k));
         cyc();
      end
      check("pre-flush count", 64'(oWB_LQ_Count), 64'd2);
      iReset = 1'b1;
      cyc();
      iReset = 1'b0;
      idle();
      cyc();
      check("flush count",   64'(oWB_LQ_Count),        64'd0);
      check("flush pending", 64'(oWB_ID_Pending),      64'd0);
      check("flush wr_en",   64'(oWB_RF_Write_Enable), 64'd0);
      check("flush ready",   64'(oWB_MEM_Ready),       64'd1);
      for (int k = 0; k < 3; k++) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
